serial_addsub: RTL

Parametrised multi-cycle ripple adder/subtractor: the next generation of the team's fixed-width combinational ripple subtractor. It processes a WIDTH-bit operation DIGIT bits per clock, least-significant slice first, so a narrow ripple chain is reused across cycles. Each operation is selected as add or subtract (a + ~b + 1). Operands arrive and results leave through valid/ready handshakes, so the block sits between an operand-issue stage and a result consumer in the datapath.

---
 rtl/serial_addsub.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Multi-cycle ripple adder/subtractor: a WIDTH-bit add or subtract is done DIGIT bits per clock, LSB slice first.
// Define SERIAL_ADDSUB_FLAGS_EN to build the overflow (out_v) and zero (out_z) flags; otherwise they are tied to 0.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE, with results held until out_ready.
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             c_q;
    logic [DIGIT-1:0] slice_s;
    logic             ripple_cout;
    logic [WIDTH-1:0] sum_next;
    logic             last_slice;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic             msb_cin;
    logic             v_q;
    logic             z_q;
`endif

    // Operands shift right each slice, so the chain always works on the low DIGIT bits.
    always_comb begin
        logic c;
        c       = carry_q;
        slice_s = '0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
        msb_cin = carry_q;
`endif
        for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADDSUB_FLAGS_EN
            msb_cin = c;
`endif
            slice_s[i] = a_q[i] ^ b_q[i] ^ c;
            c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        ripple_cout = c;
    end

    // The new slice enters at the top of the result; after N slices the LSB slice sits at bit 0.
    assign sum_next   = WIDTH'({slice_s, sum_q} >> DIGIT);
    assign last_slice = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = BUSY;
            BUSY:    if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        dbg_state = state_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
`ifdef SERIAL_ADDSUB_FLAGS_EN
            v_q     <= 1'b0;
            z_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= in_a;
                    b_q     <= in_sub ? ~in_b : in_b;
                    carry_q <= in_sub;
                    cnt_q   <= '0;
                end
                BUSY: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    sum_q   <= sum_next;
                    carry_q <= ripple_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_slice) begin
                        c_q <= ripple_cout;
`ifdef SERIAL_ADDSUB_FLAGS_EN
                        v_q <= ripple_cout ^ msb_cin;
                        z_q <= (sum_next == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_s = sum_q;
    assign out_c = c_q;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    assign out_v = v_q;
    assign out_z = z_q;
`else
    assign out_v = 1'b0;
    assign out_z = 1'b0;
`endif

endmodule
